arp_hdr_parser: RTL and testbench
=================================

ARP_HDR_PARSER -- requirements
Module: arp_hdr_parser

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, stream sideband width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for lookup_done.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  sole clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 s_axis_tdata  input  256  packet data; byte n of the beat is on bits [8n+7:8n].
REQ-008 s_axis_tkeep  input  32  byte enables; used only for the length check.
REQ-009 s_axis_tuser  input  128  sideband; ignored.
REQ-010 s_axis_tvalid  input  1  beat valid.
REQ-011 s_axis_tready  input  1  beat ready; the block is a passive tap and never drives it.
REQ-012 s_axis_tlast  input  1  last beat of a packet.
REQ-013 src_ip  output  32  sender protocol address (SPA).
REQ-014 dst_ip  output  32  target protocol address (TPA).
REQ-015 src_mac  output  48  sender hardware address (SHA).
REQ-016 opcode  output  16  ARP operation.
REQ-017 look_req  output  1  one-cycle pulse that starts a downstream CAM lookup.
REQ-018 lookup_done  input  1  one-cycle pulse from the downstream lookup.
REQ-019 lookup_timeout  output  1  one-cycle pulse when the wait for lookup_done expires.
REQ-020 arp_count  output  32  count of valid ARP frames issued downstream.
REQ-021 drop_count  output  32  count of valid ARP frames dropped because the block was busy.
REQ-022 bad_count  output  32  count of malformed ARP frames.

Function
REQ-023 A beat SHALL be counted only when tvalid&tready; a beat index of 0, 1 or saturated 2+ SHALL return to 0 after the tlast beat.
REQ-024 Field byte offsets are fixed. Beat 0: ethertype 12-13, htype 14-15, ptype 16-17, hlen 18, plen 19, oper 20-21, SHA 22-27, SPA 28-31. Beat 1: TPA bytes 6-9. All fields are big-endian on the wire.
REQ-025 Ethertype != 0x0806 SHALL cause the packet to be ignored, with no counter change.
REQ-026 An ARP frame is valid only if htype=0x0001, ptype=0x0800, hlen=6, plen=4, oper is 1 or 2, and beat 1 exists with tkeep[9:0] all set.
REQ-027 An ARP ethertype frame failing REQ-026 SHALL increment bad_count once and produce no look_req; this includes tlast on beat 0.
REQ-028 The state machine SHALL have states IDLE, CAPTURE, REQ and WAIT_DONE.
REQ-029 IDLE→CAPTURE on an accepted beat 0 with ARP ethertype.
REQ-030 CAPTURE→REQ when beat 1 is accepted and the frame is valid. CAPTURE→IDLE when the frame is invalid.
REQ-031 REQ SHALL drive look_req=1 for exactly one cycle, then go to WAIT_DONE; this is the cycle after the beat-1 accept.
REQ-032 WAIT_DONE→IDLE on lookup_done, or after TIMEOUT_CYCLES cycles, which also pulses lookup_timeout.
REQ-033 src_ip, dst_ip, src_mac and opcode SHALL be registered and held stable from look_req until leaving WAIT_DONE.
REQ-034 A valid ARP frame completing in REQ or WAIT_DONE SHALL be dropped and SHALL increment drop_count; the held outputs SHALL not change.
REQ-035 If lookup_done and a valid beat-1 accept occur in the same cycle, the block SHALL go to REQ with the new frame and SHALL not count a drop.
REQ-036 lookup_done outside WAIT_DONE SHALL be ignored.
REQ-037 Counters SHALL saturate at 0xFFFFFFFF; arp_count SHALL increment in the look_req cycle.
REQ-038 Non-ARP traffic SHALL be parsed for packet boundaries only, including while busy.

Reset
REQ-039 While reset=0 at a clock edge, the state SHALL be IDLE, the beat index 0, the timeout counter 0, and every output 0.
REQ-040 Reset mid-packet SHALL discard the packet; beats after the release are treated as beat 0 only after the next tlast.

Verification
REQ-041 ARP request with SPA 10.0.0.1, TPA 10.0.0.2, SHA 00:11:22:33:44:55, lookup_done 3 cycles after look_req -> look_req one cycle after beat 1, src_ip=0x0A000001, dst_ip=0x0A000002, src_mac=0x001122334455, opcode=0x0001, arp_count=1.
REQ-042 IPv4 frame (ethertype 0x0800) -> no look_req, all counters unchanged.
REQ-043 ARP frame with hlen=8, and a one-beat ARP frame -> bad_count=2, no look_req.
REQ-044 Second valid ARP frame while in WAIT_DONE -> drop_count=1, outputs keep first-frame values; lookup_done in the same cycle as a beat-1 accept -> new look_req, drop_count unchanged.
REQ-045 No lookup_done -> lookup_timeout pulses 64 cycles after entering WAIT_DONE, the state returns to IDLE, and the next ARP frame is issued.
REQ-046 reset=0 asserted during CAPTURE -> outputs 0; the packet is not issued; the next full ARP frame is issued normally.

Source files
------------

// File: rtl/arp_hdr_parser.sv
// rtl/arp_hdr_parser.sv - passive ARP header tap: validates frames, issues CAM lookups, counts outcomes
module arp_hdr_parser #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int TIMEOUT_CYCLES       = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                               s_axis_tvalid,
    input  logic                               s_axis_tready,
    input  logic                               s_axis_tlast,
    output logic [31:0]                        src_ip,
    output logic [31:0]                        dst_ip,
    output logic [47:0]                        src_mac,
    output logic [15:0]                        opcode,
    output logic                               look_req,
    input  logic                               lookup_done,
    output logic                               lookup_timeout,
    output logic [31:0]                        arp_count,
    output logic [31:0]                        drop_count,
    output logic [31:0]                        bad_count
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, REQ, WAIT_DONE} state_t;

    state_t              state, state_nx;
    logic [1:0]          beat_idx;
    logic                resync;
    logic                cand;
    logic                hdr_ok;
    logic [47:0]         cap_sha;
    logic [31:0]         cap_spa;
    logic [15:0]         cap_oper;
    logic [TCNT_W-1:0]   tcnt;

    logic                accept, beat0, beat1, arp_beat0, frame_done, frame_ok, bad_evt;
    logic                hdr_ok_now, issue, drop, expire, release_busy;
    logic [15:0]         ethertype, htype, ptype, oper;
    logic [7:0]          hlen, plen;
    logic [47:0]         sha;
    logic [31:0]         spa, tpa;
    logic                unused_bits;

    assign unused_bits = ^{s_axis_tuser, s_axis_tdata, s_axis_tkeep};

    assign ethertype = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    assign htype     = {s_axis_tdata[8*14 +: 8], s_axis_tdata[8*15 +: 8]};
    assign ptype     = {s_axis_tdata[8*16 +: 8], s_axis_tdata[8*17 +: 8]};
    assign hlen      = s_axis_tdata[8*18 +: 8];
    assign plen      = s_axis_tdata[8*19 +: 8];
    assign oper      = {s_axis_tdata[8*20 +: 8], s_axis_tdata[8*21 +: 8]};
    assign sha       = {s_axis_tdata[8*22 +: 8], s_axis_tdata[8*23 +: 8], s_axis_tdata[8*24 +: 8],
                        s_axis_tdata[8*25 +: 8], s_axis_tdata[8*26 +: 8], s_axis_tdata[8*27 +: 8]};
    assign spa       = {s_axis_tdata[8*28 +: 8], s_axis_tdata[8*29 +: 8],
                        s_axis_tdata[8*30 +: 8], s_axis_tdata[8*31 +: 8]};
    assign tpa       = {s_axis_tdata[8*6 +: 8], s_axis_tdata[8*7 +: 8],
                        s_axis_tdata[8*8 +: 8], s_axis_tdata[8*9 +: 8]};

    // After reset the tap is blind until a tlast realigns it to a packet boundary.
    assign accept     = s_axis_tvalid & s_axis_tready;
    assign beat0      = accept & ~resync & (beat_idx == 2'd0);
    assign beat1      = accept & ~resync & (beat_idx == 2'd1);
    assign arp_beat0  = beat0 & (ethertype == 16'h0806);
    assign hdr_ok_now = (htype == 16'h0001) && (ptype == 16'h0800) && (hlen == 8'd6) &&
                        (plen == 8'd4) && ((oper == 16'h0001) || (oper == 16'h0002));
    assign frame_done = beat1 & cand;
    assign frame_ok   = frame_done & hdr_ok & (&s_axis_tkeep[9:0]);
    assign bad_evt    = (arp_beat0 & s_axis_tlast) | (frame_done & ~frame_ok);

    assign look_req   = (state == REQ);

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_comb begin
        state_nx     = state;
        issue        = 1'b0;
        drop         = 1'b0;
        expire       = (state == WAIT_DONE) && (tcnt == TCNT_LAST) && !lookup_done;
        release_busy = (state == WAIT_DONE) && (lookup_done || expire);
        case (state)
            IDLE: begin
                if (frame_ok)
                    issue = 1'b1;
                else if (arp_beat0 && !s_axis_tlast)
                    state_nx = CAPTURE;
            end
            CAPTURE: begin
                if (frame_ok)
                    issue = 1'b1;
                else if (frame_done)
                    state_nx = IDLE;
            end
            REQ: begin
                state_nx = WAIT_DONE;
                drop     = frame_ok;
            end
            WAIT_DONE: begin
                if (release_busy) begin
                    if (frame_ok)
                        issue = 1'b1;
                    else
                        state_nx = IDLE;
                end else begin
                    drop = frame_ok;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (issue)
            state_nx = REQ;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            beat_idx       <= 2'd0;
            resync         <= 1'b1;
            cand           <= 1'b0;
            hdr_ok         <= 1'b0;
            cap_sha        <= '0;
            cap_spa        <= '0;
            cap_oper       <= '0;
            tcnt           <= '0;
            lookup_timeout <= 1'b0;
            src_ip         <= '0;
            dst_ip         <= '0;
            src_mac        <= '0;
            opcode         <= '0;
            arp_count      <= '0;
            drop_count     <= '0;
            bad_count      <= '0;
        end else begin
            state          <= state_nx;
            lookup_timeout <= expire;
            tcnt           <= (state == WAIT_DONE && state_nx == WAIT_DONE) ? tcnt + 1'b1 : '0;

            if (accept) begin
                if (s_axis_tlast) begin
                    beat_idx <= 2'd0;
                    resync   <= 1'b0;
                end else if (beat_idx != 2'd2) begin
                    beat_idx <= beat_idx + 2'd1;
                end
            end

            // Shadow capture runs even while busy so a later frame can be judged; held outputs stay put.
            if (arp_beat0) begin
                cand     <= !s_axis_tlast;
                hdr_ok   <= hdr_ok_now;
                cap_sha  <= sha;
                cap_spa  <= spa;
                cap_oper <= oper;
            end else if (frame_done) begin
                cand <= 1'b0;
            end

            if (issue) begin
                src_ip    <= cap_spa;
                dst_ip    <= tpa;
                src_mac   <= cap_sha;
                opcode    <= cap_oper;
                arp_count <= sat_inc(arp_count);
            end
            if (drop)
                drop_count <= sat_inc(drop_count);
            if (bad_evt)
                bad_count <= sat_inc(bad_count);
        end
    end

endmodule

// File: tb/tb_arp_hdr_parser.sv
// tb/tb_arp_hdr_parser.sv - directed and randomized ARP frames checked against a frame-level model
module tb_arp_hdr_parser;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [31:0]  src_ip, dst_ip;
    logic [47:0]  src_mac;
    logic [15:0]  opcode;
    logic         look_req, lookup_done, lookup_timeout;
    logic [31:0]  arp_count, drop_count, bad_count;

    always #5 clk = ~clk;

    arp_hdr_parser dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .src_ip(src_ip), .dst_ip(dst_ip), .src_mac(src_mac), .opcode(opcode),
        .look_req(look_req), .lookup_done(lookup_done), .lookup_timeout(lookup_timeout),
        .arp_count(arp_count), .drop_count(drop_count), .bad_count(bad_count)
    );

    typedef struct {
        logic [15:0] et, ht, pt, op;
        logic [7:0]  hl, pl;
        logic [47:0] sha;
        logic [31:0] spa, tpa;
        logic [9:0]  keep1lo;
        int          nbeats;
    } frame_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int lr_count = 0, lr_cycle = -1, to_count = 0, to_cycle = -1;
    always @(negedge clk) begin
        if (look_req === 1'b1) begin
            lr_count = lr_count + 1;
            lr_cycle = cyc;
        end
        if (lookup_timeout === 1'b1) begin
            to_count = to_count + 1;
            to_cycle = cyc;
        end
    end

    int          n_total = 0, n_bad = 0;
    int          exp_arp, exp_drop, exp_bad, exp_lr = 0, issue_cyc = 0;
    bit          busy;
    logic [31:0] h_src, h_dst;
    logic [47:0] h_mac;
    logic [15:0] h_op;
    logic [15:0] other_et [5] = '{16'h0800, 16'h86DD, 16'h8100, 16'h0805, 16'h0807};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] put(input logic [255:0] d, input int off, input int n, input logic [63:0] v);
        logic [255:0] r;
        r = d;
        for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = v[8*(n-1-i) +: 8];
        return r;
    endfunction

    function automatic frame_t rand_valid();
        frame_t f;
        f.et = 16'h0806; f.ht = 16'h0001; f.pt = 16'h0800; f.hl = 8'd6; f.pl = 8'd4;
        f.op = 16'($urandom_range(1, 2));
        f.sha = {16'($urandom), 32'($urandom)};
        f.spa = $urandom;
        f.tpa = $urandom;
        f.keep1lo = 10'h3FF;
        f.nbeats = $urandom_range(2, 4);
        return f;
    endfunction

    function automatic frame_t corrupt(input frame_t fin, input int sel);
        frame_t f;
        int     k;
        f = fin;
        case (sel)
            0: f.ht = 16'h0006;
            1: f.pt = 16'h86DD;
            2: f.hl = 8'd8;
            3: f.pl = 8'd16;
            4: f.op = ($urandom_range(0, 1) == 1) ? 16'h0003 : 16'h0000;
            5: begin k = $urandom_range(0, 9); f.keep1lo[k] = 1'b0; end
            default: f.nbeats = 1;
        endcase
        return f;
    endfunction

    function automatic logic [255:0] beat0_data(input frame_t f);
        logic [255:0] d;
        d = put(rnd256(), 12, 2, 64'(f.et));
        d = put(d, 14, 2, 64'(f.ht));
        d = put(d, 16, 2, 64'(f.pt));
        d = put(d, 18, 1, 64'(f.hl));
        d = put(d, 19, 1, 64'(f.pl));
        d = put(d, 20, 2, 64'(f.op));
        d = put(d, 22, 6, 64'(f.sha));
        d = put(d, 28, 4, 64'(f.spa));
        return d;
    endfunction

    function automatic logic [255:0] beat1_data(input frame_t f);
        return put(rnd256(), 6, 4, 64'(f.tpa));
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic last,
                             input logic done_here, output int acc);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        s_axis_tready = 1'b1;
        lookup_done   = done_here;
        step();
        acc           = cyc;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        lookup_done   = 1'b0;
        s_axis_tready = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 1)) step();
    endtask

    task automatic send_frame(input frame_t f, input bit done_on_b1, output int acc1);
        int a;
        acc1 = -1;
        send_beat(beat0_data(f), 32'hFFFF_FFFF, f.nbeats == 1, 1'b0, a);
        if (f.nbeats >= 2)
            send_beat(beat1_data(f), {22'($urandom), f.keep1lo}, f.nbeats == 2, done_on_b1, acc1);
        for (int b = 2; b < f.nbeats; b++)
            send_beat(rnd256(), 32'hFFFF_FFFF, b == f.nbeats - 1, 1'b0, a);
        step();
    endtask

    task automatic model_reset();
        exp_arp = 0; exp_drop = 0; exp_bad = 0; busy = 0;
        h_src = '0; h_dst = '0; h_mac = '0; h_op = '0;
    endtask

    // Frame-level outcome: ignored, malformed, issued when free, dropped when busy.
    task automatic model_frame(input frame_t f, input int acc1, input bit done_same, output bit issued);
        bit valid;
        issued = 0;
        if (done_same) busy = 0;
        if (f.et != 16'h0806) return;
        valid = (f.ht == 16'h0001) && (f.pt == 16'h0800) && (f.hl == 8'd6) && (f.pl == 8'd4) &&
                (f.op == 16'h0001 || f.op == 16'h0002) && (f.nbeats >= 2) && (f.keep1lo == 10'h3FF);
        if (!valid) begin
            exp_bad++;
        end else if (busy) begin
            exp_drop++;
        end else begin
            issued = 1; busy = 1; issue_cyc = acc1;
            exp_arp++; exp_lr++;
            h_src = f.spa; h_dst = f.tpa; h_mac = f.sha; h_op = f.op;
        end
    endtask

    task automatic check_state(input string tag, input bit issued, input int acc1);
        chk({tag, ".arp_count"}, arp_count, exp_arp);
        chk({tag, ".drop_count"}, drop_count, exp_drop);
        chk({tag, ".bad_count"}, bad_count, exp_bad);
        chk({tag, ".look_reqs"}, lr_count, exp_lr);
        chk({tag, ".src_ip"}, src_ip, h_src);
        chk({tag, ".dst_ip"}, dst_ip, h_dst);
        chk({tag, ".src_mac"}, src_mac, h_mac);
        chk({tag, ".opcode"}, opcode, h_op);
        if (issued) chk({tag, ".look_req_cycle"}, lr_cycle, acc1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".src_ip"}, src_ip, 0);
        chk({tag, ".dst_ip"}, dst_ip, 0);
        chk({tag, ".src_mac"}, src_mac, 0);
        chk({tag, ".opcode"}, opcode, 0);
        chk({tag, ".look_req"}, look_req, 0);
        chk({tag, ".lookup_timeout"}, lookup_timeout, 0);
        chk({tag, ".arp_count"}, arp_count, 0);
        chk({tag, ".drop_count"}, drop_count, 0);
        chk({tag, ".bad_count"}, bad_count, 0);
    endtask

    task automatic pulse_done();
        while (cyc <= issue_cyc) step();
        lookup_done = 1'b1;
        step();
        lookup_done = 1'b0;
        busy = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        frame_t f;
        int     a, t0, sel;
        bit     issued;

        reset = 1'b0; s_axis_tvalid = 1'b0; s_axis_tready = 1'b1; s_axis_tlast = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; lookup_done = 1'b0;
        model_reset();
        repeat (3) step();
        check_zero("reset");
        reset = 1'b1;

        // Beats before the first tlast after reset are not parsed, even a one-beat ARP frame.
        f = rand_valid(); f.nbeats = 1;
        send_frame(f, 0, a);
        check_state("flush", 0, a);

        f = rand_valid(); f.op = 16'h0001; f.spa = 32'h0A00_0001; f.tpa = 32'h0A00_0002;
        f.sha = 48'h0011_2233_4455;
        send_frame(f, 0, a);
        model_frame(f, a, 0, issued);
        check_state("arp_req", issued, a);
        chk("arp_req.arp_count_is_1", arp_count, 1);
        while (cyc < issue_cyc + 3) step();
        lookup_done = 1'b1; step(); lookup_done = 1'b0; busy = 0;
        repeat (3) step();
        chk("arp_req.no_timeout", to_count, 0);

        f = rand_valid(); f.et = 16'h0800;
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("ipv4", issued, a);

        f = rand_valid(); f.hl = 8'd8;
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("hlen8", issued, a);
        f = rand_valid(); f.nbeats = 1;
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("one_beat", issued, a);
        chk("bad.bad_count_is_2", bad_count, 2);

        f = rand_valid();
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("busy_a", issued, a);
        f = rand_valid();
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("busy_drop", issued, a);
        chk("busy.drop_count_is_1", drop_count, 1);
        f = rand_valid(); f.nbeats = 2;
        send_frame(f, 1, a); model_frame(f, a, 1, issued); check_state("done_same_cycle", issued, a);
        pulse_done();

        f = rand_valid();
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("to_issue", issued, a);
        t0 = to_count;
        for (int i = 0; i < 200; i++) begin
            if (to_count != t0) break;
            step();
        end
        chk("timeout.pulses", to_count, t0 + 1);
        chk("timeout.cycle", to_cycle, issue_cyc + 65);
        busy = 0;
        f = rand_valid();
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("after_timeout", issued, a);
        chk("timeout.single_pulse", to_count, t0 + 1);
        pulse_done();

        f = rand_valid();
        send_beat(beat0_data(f), 32'hFFFF_FFFF, 1'b0, 1'b0, a);
        reset = 1'b0;
        repeat (2) step();
        check_zero("reset_capture");
        reset = 1'b1;
        model_reset();
        send_beat(beat1_data(f), 32'hFFFF_FFFF, 1'b1, 1'b0, a);
        step();
        check_state("reset_tail", 0, a);
        f = rand_valid();
        send_frame(f, 0, a); model_frame(f, a, 0, issued); check_state("after_reset", issued, a);
        chk("after_reset.arp_count_is_1", arp_count, 1);

        for (int it = 0; it < 40; it++) begin
            if (busy && (($urandom_range(0, 1) == 1) || (cyc - issue_cyc > 25)))
                pulse_done();
            else if (!busy && $urandom_range(0, 3) == 0)
                pulse_done();
            f = rand_valid();
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                f.et = other_et[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) == 0) f.nbeats = 1;
            end else if (sel < 6) begin
                f = corrupt(f, $urandom_range(0, 6));
            end
            send_frame(f, 0, a);
            model_frame(f, a, 0, issued);
            check_state($sformatf("rnd%0d", it), issued, a);
        end
        if (busy) pulse_done();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
